// File: rtl/wb_msp_tx_framer.sv
// Wishbone-mapped MSP frame transmitter: buffers payload bytes in a FIFO and
// streams "$M> size cmd payload csum" frames toward a UART with valid/ready.
module wb_msp_tx_framer #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] wb_dat_i,
    input  logic [31:0] wb_adr_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_stall_o,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        frame_done,
    output logic        busy
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0]   DEPTH_W  = FIFO_DEPTH;
    localparam logic [AW-1:0] LAST_PTR = AW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR0, S_HDR1, S_HDR2, S_SIZE, S_CMD, S_PAYLOAD, S_CSUM
    } state_t;

    state_t        state_q, state_d;
    logic          ack_q, ack_d;
    logic [31:0]   dat_o_q, dat_o_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          frame_done_q, frame_done_d;
    logic [7:0]    cmd_q, cmd_d, f_cmd_q, f_cmd_d;
    logic [4:0]    size_q, size_d, f_size_q, f_size_d;
    logic          dir_q, dir_d, f_dir_q, f_dir_d;
    logic [4:0]    pay_cnt_q, pay_cnt_d;
    logic [7:0]    csum_q, csum_d;
    logic          overflow_q, overflow_d;
    logic          start_err_q, start_err_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];

    logic       sel, access, wr_acc, wr_ctrl, wr_data, wr_status;
    logic       full, start_ok, accept, push, pop;
    logic [1:0] reg_idx;
    logic       unused_inputs;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + AW'(1);
    endfunction

    assign unused_inputs = ^{wb_sel_i, wb_adr_i[31:12], wb_adr_i[1:0],
                             wb_dat_i[30:17], wb_dat_i[15:13]};

    assign sel       = wb_cyc_i & wb_stb_i & (wb_adr_i[11:4] == 8'h50);
    assign access    = sel & ~ack_q;
    assign wr_acc    = access & wb_we_i;
    assign reg_idx   = wb_adr_i[3:2];
    assign wr_ctrl   = wr_acc & (reg_idx == 2'd0);
    assign wr_data   = wr_acc & (reg_idx == 2'd1);
    assign wr_status = wr_acc & (reg_idx == 2'd2);
    assign full      = (count_q == FULL_CNT);
    // A start only launches when the whole payload is already buffered.
    assign start_ok  = wr_ctrl & wb_dat_i[31] & (state_q == S_IDLE)
                     & (32'(wb_dat_i[12:8]) <= DEPTH_W)
                     & (32'(wb_dat_i[12:8]) <= 32'(count_q));
    assign accept    = tx_valid & tx_ready;
    assign push      = wr_data & ~full;
    assign pop       = accept & (state_q == S_PAYLOAD);

    always_comb begin
        ack_d       = sel & ~ack_q;
        dat_o_d     = '0;
        cmd_d       = cmd_q;
        size_d      = size_q;
        dir_d       = dir_q;
        overflow_d  = overflow_q;
        start_err_d = start_err_q;
        wr_ptr_d    = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d    = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d     = count_q + CW'(push) - CW'(pop);
        mem_d       = mem_q;
        if (access && !wb_we_i) begin
            case (reg_idx)
                2'd0:    dat_o_d = {15'b0, dir_q, 3'b0, size_q, cmd_q};
                2'd2:    dat_o_d = {22'b0, start_err_q, overflow_q, 2'b0,
                                    5'(count_q), busy};
                default: dat_o_d = '0;
            endcase
        end
        if (wr_ctrl) begin
            cmd_d  = wb_dat_i[7:0];
            size_d = wb_dat_i[12:8];
            dir_d  = wb_dat_i[16];
            if (wb_dat_i[31] && !start_ok) start_err_d = 1'b1;
        end
        if (wr_status && wb_dat_i[8]) overflow_d  = 1'b0;
        if (wr_status && wb_dat_i[9]) start_err_d = 1'b0;
        if (wr_data && full)          overflow_d  = 1'b1;
        if (push) mem_d[wr_ptr_q] = wb_dat_i[7:0];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start_ok) state_d = S_HDR0;
            S_HDR0:    if (accept) state_d = S_HDR1;
            S_HDR1:    if (accept) state_d = S_HDR2;
            S_HDR2:    if (accept) state_d = S_SIZE;
            S_SIZE:    if (accept) state_d = S_CMD;
            S_CMD:     if (accept) state_d = (f_size_q == 5'd0) ? S_CSUM : S_PAYLOAD;
            S_PAYLOAD: if (accept && (pay_cnt_q + 5'd1 == f_size_q)) state_d = S_CSUM;
            S_CSUM:    if (accept) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // The frame works from a snapshot of cmd/size/dir so later CTRL writes cannot corrupt it.
    always_comb begin
        tx_data_d    = tx_data_q;
        csum_d       = csum_q;
        pay_cnt_d    = pay_cnt_q;
        f_cmd_d      = f_cmd_q;
        f_size_d     = f_size_q;
        f_dir_d      = f_dir_q;
        frame_done_d = accept & (state_q == S_CSUM);
        if (start_ok) begin
            tx_data_d = 8'h24;
            csum_d    = '0;
            pay_cnt_d = '0;
            f_cmd_d   = wb_dat_i[7:0];
            f_size_d  = wb_dat_i[12:8];
            f_dir_d   = wb_dat_i[16];
        end else if (accept) begin
            if (state_q inside {S_SIZE, S_CMD, S_PAYLOAD}) csum_d = csum_q ^ tx_data_q;
            if (pop) pay_cnt_d = pay_cnt_q + 5'd1;
            case (state_d)
                S_HDR1:    tx_data_d = 8'h4D;
                S_HDR2:    tx_data_d = f_dir_q ? 8'h21 : 8'h3E;
                S_SIZE:    tx_data_d = {3'b0, f_size_q};
                S_CMD:     tx_data_d = f_cmd_q;
                S_PAYLOAD: tx_data_d = (state_q == S_PAYLOAD) ? mem_q[ptr_inc(rd_ptr_q)]
                                                              : mem_q[rd_ptr_q];
                S_CSUM:    tx_data_d = csum_d;
                default:   tx_data_d = tx_data_q;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q        <= 1'b0;
            dat_o_q      <= '0;
            tx_data_q    <= '0;
            frame_done_q <= 1'b0;
            cmd_q        <= '0;
            size_q       <= '0;
            dir_q        <= 1'b0;
            f_cmd_q      <= '0;
            f_size_q     <= '0;
            f_dir_q      <= 1'b0;
            pay_cnt_q    <= '0;
            csum_q       <= '0;
            overflow_q   <= 1'b0;
            start_err_q  <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            ack_q        <= ack_d;
            dat_o_q      <= dat_o_d;
            tx_data_q    <= tx_data_d;
            frame_done_q <= frame_done_d;
            cmd_q        <= cmd_d;
            size_q       <= size_d;
            dir_q        <= dir_d;
            f_cmd_q      <= f_cmd_d;
            f_size_q     <= f_size_d;
            f_dir_q      <= f_dir_d;
            pay_cnt_q    <= pay_cnt_d;
            csum_q       <= csum_d;
            overflow_q   <= overflow_d;
            start_err_q  <= start_err_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        mem_q <= mem_d;
    end

    assign wb_dat_o   = dat_o_q;
    assign wb_ack_o   = ack_q;
    assign wb_stall_o = 1'b0;
    assign tx_data    = tx_data_q;
    assign tx_valid   = (state_q != S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_wb_msp_tx_framer.sv
// Scoreboard bench for wb_msp_tx_framer: a register/frame model queues expected
// UART bytes; an independent monitor pops and compares them on each handshake.
module tb_wb_msp_tx_framer;

    localparam int DEPTH = 16;
    localparam logic [31:0] A_CTRL = 32'h0000_0500;
    localparam logic [31:0] A_DATA = 32'h0000_0504;
    localparam logic [31:0] A_STAT = 32'h0000_0508;
    localparam logic [31:0] A_RSV  = 32'h0000_050C;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wb_dat_i, wb_adr_i, wb_dat_o;
    logic        wb_we_i, wb_stb_i, wb_cyc_i, wb_ack_o, wb_stall_o;
    logic [3:0]  wb_sel_i;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready, frame_done, busy;

    typedef struct {
        logic [7:0] data;
        bit         last;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_fifo[$];
    logic [7:0] m_cmd;
    logic [4:0] m_size;
    logic       m_dir, m_ovf, m_serr;
    bit         model_busy, pending_done;
    bit         ready_hold, ready_rand;
    int         m_cur_size, frames_started, done_count, bytes_seen;
    int         n_checks, n_fail;

    wb_msp_tx_framer #(.FIFO_DEPTH(DEPTH)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wb_dat_i  (wb_dat_i),
        .wb_adr_i  (wb_adr_i),
        .wb_we_i   (wb_we_i),
        .wb_sel_i  (wb_sel_i),
        .wb_stb_i  (wb_stb_i),
        .wb_cyc_i  (wb_cyc_i),
        .wb_dat_o  (wb_dat_o),
        .wb_ack_o  (wb_ack_o),
        .wb_stall_o(wb_stall_o),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .frame_done(frame_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: bound expired", name);
    endtask

    function automatic void exp_push(input logic [7:0] d, input bit last);
        exp_t e;
        e.data = d;
        e.last = last;
        exp_q.push_back(e);
    endfunction

    // Frame model: header, size, cmd, payload taken from the buffered bytes, XOR checksum.
    function automatic void model_start_frame();
        logic [7:0] sum;
        logic [7:0] b;
        sum = {3'b0, m_size} ^ m_cmd;
        exp_push(8'h24, 0);
        exp_push(8'h4D, 0);
        exp_push(m_dir ? 8'h21 : 8'h3E, 0);
        exp_push({3'b0, m_size}, 0);
        exp_push(m_cmd, 0);
        for (int i = 0; i < int'(m_size); i++) begin
            b = model_fifo.pop_front();
            sum = sum ^ b;
            exp_push(b, 0);
        end
        exp_push(sum, 1);
        model_busy     = 1;
        m_cur_size     = int'(m_size);
        frames_started = frames_started + 1;
        bytes_seen     = 0;
    endfunction

    function automatic void model_write(input logic [31:0] addr, input logic [31:0] d);
        if (addr == A_CTRL) begin
            m_cmd  = d[7:0];
            m_size = d[12:8];
            m_dir  = d[16];
            if (d[31]) begin
                if (!model_busy && int'(m_size) <= DEPTH && int'(m_size) <= model_fifo.size())
                    model_start_frame();
                else
                    m_serr = 1;
            end
        end else if (addr == A_DATA) begin
            if (model_fifo.size() >= DEPTH) m_ovf = 1;
            else model_fifo.push_back(d[7:0]);
        end else if (addr == A_STAT) begin
            if (d[8]) m_ovf = 0;
            if (d[9]) m_serr = 0;
        end
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        logic [31:0] r;
        r = 0;
        if (addr == A_CTRL)
            r = (32'(m_dir) << 16) + (32'(m_size) << 8) + 32'(m_cmd);
        else if (addr == A_STAT)
            r = (32'(m_serr) << 9) + (32'(m_ovf) << 8)
              + (32'(model_fifo.size()) << 1) + 32'(model_busy);
        return r;
    endfunction

    function automatic void model_reset();
        model_fifo.delete();
        exp_q.delete();
        m_cmd = 0; m_size = 0; m_dir = 0; m_ovf = 0; m_serr = 0;
        if (model_busy) frames_started = frames_started - 1;
        model_busy   = 0;
        pending_done = 0;
    endfunction

    task automatic wb_cycle(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata);
        bit got;
        got   = 0;
        rdata = '0;
        @(posedge clk); #1;
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_adr_i = addr; wb_dat_i = wdata;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (wb_ack_o) begin
                got   = 1;
                rdata = wb_dat_o;
            end
        end
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
        if (!got) fail_now("wb_ack");
    endtask

    task automatic apply_stimulus(input logic [31:0] addr, input logic [31:0] d);
        logic [31:0] dummy;
        wb_cycle(1'b1, addr, d, dummy);
        model_write(addr, d);
    endtask

    task automatic read_check(input logic [31:0] addr, input string name);
        logic [31:0] r;
        wb_cycle(1'b0, addr, 32'h0, r);
        check_output(name, r, model_read(addr));
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk); #1;
        rst = 1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 600 && (model_busy || pending_done || exp_q.size() != 0); i++)
            @(posedge clk);
        if (model_busy || pending_done || exp_q.size() != 0) begin
            fail_now("frame completion");
            do_reset(1);
        end
    endtask

    task automatic wait_bytes(input int n);
        for (int i = 0; i < 300 && bytes_seen < n; i++) @(negedge clk);
        if (bytes_seen < n) fail_now("byte count");
    endtask

    function automatic logic [31:0] ctrl_word(input bit start, input bit dir,
                                              input int size, input logic [7:0] cmd);
        return (32'(start) << 31) + (32'(dir) << 16) + (32'(5'(size)) << 8) + 32'(cmd);
    endfunction

    // UART side: tx_ready is either held low, randomised, or always high.
    initial begin
        tx_ready = 1;
        forever begin
            @(posedge clk); #1;
            if (ready_hold)      tx_ready = 0;
            else if (ready_rand) tx_ready = ($urandom_range(0, 3) != 0);
            else                 tx_ready = 1;
        end
    end

    // Monitor: pops the scoreboard on each accepted byte and checks stall stability.
    initial begin : monitor
        exp_t       e;
        logic       prev_valid, prev_ready, prev_rst;
        logic [7:0] prev_data;
        prev_valid = 0; prev_ready = 0; prev_rst = 1; prev_data = 0;
        forever begin
            @(negedge clk);
            if (pending_done) begin
                check_output("frame_done pulse", frame_done, 1);
                check_output("busy at frame_done", busy, 0);
                check_output("tx_valid after csum", tx_valid, 0);
                pending_done = 0;
                done_count   = done_count + 1;
                model_busy   = 0;
            end else if (frame_done) begin
                check_output("unexpected frame_done", frame_done, 0);
            end
            if (prev_valid && !prev_ready && !prev_rst && !rst) begin
                check_output("stall tx_valid", tx_valid, 1);
                check_output("stall tx_data", tx_data, prev_data);
            end
            if (tx_valid && tx_ready && !rst) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected tx byte", tx_data, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check_output("tx byte", tx_data, e.data);
                    bytes_seen = bytes_seen + 1;
                    if (e.last) pending_done = 1;
                end
            end
            prev_valid = tx_valid;
            prev_ready = tx_ready;
            prev_rst   = rst;
            prev_data  = tx_data;
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin : stimulus
        int lvl, sz, op;
        n_checks = 0; n_fail = 0;
        frames_started = 0; done_count = 0; bytes_seen = 0;
        model_busy = 0; pending_done = 0; ready_hold = 0; ready_rand = 0;
        rst = 1;
        wb_dat_i = 0; wb_adr_i = 0; wb_we_i = 0; wb_sel_i = 4'hF; wb_stb_i = 0; wb_cyc_i = 0;
        do_reset(3);

        check_output("reset wb_ack_o", wb_ack_o, 0);
        check_output("reset wb_dat_o", wb_dat_o, 0);
        check_output("reset tx_valid", tx_valid, 0);
        check_output("reset tx_data", tx_data, 0);
        check_output("reset frame_done", frame_done, 0);
        check_output("reset busy", busy, 0);
        check_output("wb_stall_o", wb_stall_o, 0);
        read_check(A_STAT, "reset status");
        read_check(A_CTRL, "reset ctrl");

        // Two-byte payload frame.
        apply_stimulus(A_DATA, 32'h01);
        apply_stimulus(A_DATA, 32'h02);
        apply_stimulus(A_CTRL, 32'h8000_0264);
        wait_idle();
        check_output("frame_done count 2-byte", done_count, frames_started);
        read_check(A_STAT, "level after 2-byte frame");
        read_check(A_CTRL, "ctrl readback");

        // Empty payload with error direction.
        apply_stimulus(A_CTRL, 32'h8001_00F5);
        wait_idle();
        check_output("frame_done count empty", done_count, frames_started);

        // Stall during payload.
        for (int i = 0; i < 4; i++) apply_stimulus(A_DATA, $urandom_range(0, 255));
        apply_stimulus(A_CTRL, ctrl_word(1, 0, 4, 8'h6C));
        wait_bytes(6);
        ready_hold = 1;
        repeat (3) @(posedge clk);
        #2;
        ready_hold = 0;
        wait_idle();

        // Overflow, oversize start, maximum-size frame.
        for (int i = 0; i < 17; i++) apply_stimulus(A_DATA, 32'h30 + i);
        read_check(A_STAT, "status full+overflow");
        apply_stimulus(A_STAT, 32'h100);
        read_check(A_STAT, "status overflow cleared");
        apply_stimulus(A_CTRL, ctrl_word(1, 0, 17, 8'h3C));
        read_check(A_STAT, "status size>depth");
        apply_stimulus(A_STAT, 32'h200);
        apply_stimulus(A_CTRL, ctrl_word(1, 1, 16, 8'hA5));
        wait_idle();
        read_check(A_STAT, "status after max frame");

        // Start with too few bytes buffered, then start while busy.
        apply_stimulus(A_DATA, 32'h5A);
        apply_stimulus(A_CTRL, ctrl_word(1, 0, 3, 8'h11));
        repeat (4) begin
            @(negedge clk);
            check_output("no tx_valid on bad start", tx_valid, 0);
        end
        read_check(A_STAT, "status start_err");
        apply_stimulus(A_STAT, 32'h200);
        ready_hold = 1;
        apply_stimulus(A_CTRL, ctrl_word(1, 0, 1, 8'h11));
        apply_stimulus(A_CTRL, ctrl_word(1, 0, 1, 8'h11));
        ready_hold = 0;
        wait_idle();
        read_check(A_STAT, "status busy start_err");
        apply_stimulus(A_STAT, 32'h300);

        // Reset after the fourth byte of a frame.
        for (int i = 0; i < 3; i++) apply_stimulus(A_DATA, 32'hC0 + i);
        apply_stimulus(A_CTRL, ctrl_word(1, 0, 3, 8'h77));
        wait_bytes(4);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        repeat (5) begin
            @(negedge clk);
            check_output("tx_valid after abort", tx_valid, 0);
        end
        check_output("tx_data after abort", tx_data, 0);
        read_check(A_STAT, "status after abort");
        read_check(A_CTRL, "ctrl after abort");
        check_output("no frame_done on abort", done_count, frames_started);

        // Reserved and DATA reads.
        apply_stimulus(A_DATA, 32'h99);
        apply_stimulus(A_RSV, 32'hFFFF_FFFF);
        read_check(A_RSV, "reserved read");
        read_check(A_DATA, "data read");
        read_check(A_STAT, "status after reserved write");

        // Randomised traffic with random UART back-pressure.
        ready_rand = 1;
        for (int it = 0; it < 80; it++) begin
            op = $urandom_range(0, 7);
            case (op)
                0, 1, 2: begin
                    if (!model_busy || model_fifo.size() + m_cur_size < DEPTH)
                        apply_stimulus(A_DATA, $urandom);
                end
                3, 4: begin
                    wait_idle();
                    lvl = model_fifo.size();
                    if ($urandom_range(0, 9) == 0) sz = $urandom_range(17, 31);
                    else sz = $urandom_range(0, (lvl + 2 > DEPTH) ? DEPTH : lvl + 2);
                    apply_stimulus(A_CTRL, ctrl_word(1, 1'($urandom_range(0, 1)), sz,
                                                     8'($urandom_range(0, 255))));
                end
                5: begin
                    wait_idle();
                    read_check(A_STAT, "random status");
                end
                6: begin
                    wait_idle();
                    read_check(A_CTRL, "random ctrl");
                end
                default: begin
                    wait_idle();
                    apply_stimulus(A_STAT, 32'($urandom_range(0, 3)) << 8);
                end
            endcase
        end
        ready_rand = 0;
        wait_idle();
        repeat (3) @(negedge clk);
        check_output("final frame_done count", done_count, frames_started);
        check_output("scoreboard drained", exp_q.size(), 0);
        read_check(A_STAT, "final status");

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_msp_tx_framer.md
WB_MSP_TX_FRAMER -- requirements
Module: wb_msp_tx_framer

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 16, setting the payload FIFO depth in bytes and the maximum frame payload size.
REQ-002 The block SHALL have port wb_clk_i, input, 1, the single clock for all logic.
REQ-003 The block SHALL have port wb_rst_i, input, 1, the reset, which is synchronous and active-high.
REQ-004 The block SHALL have Wishbone inputs wb_dat_i[31:0], wb_adr_i[31:0], wb_we_i, wb_sel_i[3:0], wb_stb_i and wb_cyc_i, with wb_sel_i ignored.
REQ-005 The block SHALL have Wishbone outputs wb_dat_o[31:0] (registered), wb_ack_o (registered) and wb_stall_o, with wb_stall_o tied to 0.
REQ-006 The block SHALL have output tx_data, 8 bits, the byte presented toward the PC UART transmitter.
REQ-007 The block SHALL have output tx_valid, 1 bit, which is high while tx_data holds a valid byte.
REQ-008 The block SHALL have input tx_ready, 1 bit; the UART accepts a byte on any cycle where tx_valid and tx_ready are both high.
REQ-009 The block SHALL have output frame_done, 1 bit, a one-cycle pulse after the checksum byte is accepted.
REQ-010 The block SHALL have output busy, 1 bit, which is high whenever the FSM is not in S_IDLE.

Function
REQ-011 The block SHALL set sel = wb_cyc_i & wb_stb_i & (wb_adr_i[11:4]==8'h50), so it decodes base address 0x0500.
REQ-012 The block SHALL drive wb_ack_o <= sel & ~wb_ack_o, giving one ack per access, and SHALL take register side effects only on the cycle where sel & ~wb_ack_o.
REQ-013 The CTRL register at 0x0500 SHALL be writable with the following fields:
- [7:0] cmd
- [12:8] size
- [16] dir_err, which selects '!' (0x21) in place of '>' (0x3E)
- [31] start
A read of CTRL SHALL return the last written cmd, size and dir_err, with [31] reading 0.
REQ-014 Writing 0x0504 (DATA) SHALL push wb_dat_i[7:0] into the payload FIFO, and a read of DATA SHALL return 0.
REQ-015 The STATUS register at 0x0508 SHALL read as follows:
- [0] busy
- [5:1] fifo_level (0..FIFO_DEPTH)
- [8] overflow (sticky)
- [9] start_err (sticky)
Writing 1 to [8] or [9] SHALL clear that bit.
REQ-016 Address 0x050C SHALL be acked, SHALL read 0, and writes to it SHALL be ignored.
REQ-017 A DATA write while the FIFO is full SHALL be dropped and SHALL set overflow; this holds even if a pop occurs in the same cycle.
REQ-018 A CTRL write with start=1 SHALL be accepted only when all of the following hold:
- FSM is in S_IDLE
- size <= FIFO_DEPTH
- size <= fifo_level
Otherwise the frame SHALL NOT start, start_err SHALL be set, and the FIFO SHALL be untouched. The cmd, size and dir_err fields are still latched in every case.
REQ-019 The FSM SHALL have states S_IDLE, S_HDR0, S_HDR1, S_HDR2, S_SIZE, S_CMD, S_PAYLOAD and S_CSUM.
REQ-020 An accepted start SHALL move the FSM to S_HDR0, and tx_valid SHALL rise on the cycle after the ack edge with tx_data = 0x24 ('$').
REQ-021 The byte sequence SHALL be:
- 0x24, then 0x4D ('M')
- 0x3E or 0x21
- size, then cmd
- size payload bytes, popped from the FIFO in order
- checksum
REQ-022 The checksum SHALL be the 8-bit XOR of size, cmd and every payload byte, computed incrementally.
REQ-023 The FSM SHALL advance only on tx_valid & tx_ready, SHALL present the next byte on the following cycle with tx_valid held high (no bubbles), and SHALL hold tx_data stable while tx_ready is low.
REQ-024 When size = 0, the FSM SHALL go from S_CMD directly to S_CSUM.
REQ-025 The FIFO SHALL pop on acceptance of each payload byte, and the payload byte counter SHALL be 5 bits.
REQ-026 On acceptance of the checksum byte, the block SHALL:
- set tx_valid=0 on the next cycle
- pulse frame_done for 1 cycle
- return the FSM to S_IDLE
REQ-027 DATA writes during a frame SHALL be allowed, so a simultaneous push and pop is legal and fifo_level stays constant.
REQ-028 The block SHALL leave tx_data unchanged while tx_valid=0.

Reset
REQ-029 While wb_rst_i=1 on a clock edge, the block SHALL clear all of the following:
- outputs: wb_ack_o, wb_dat_o, tx_valid, tx_data, frame_done, busy (all 0)
- FIFO emptied, fifo_level=0
- overflow=0, start_err=0
- cmd, size and dir_err = 0
- FSM in S_IDLE
REQ-030 A reset asserted mid-frame SHALL abort the frame immediately, with tx_valid=0 on the following cycle and no frame_done.

Verification
REQ-031 Write DATA 0x01, then 0x02, then CTRL 0x8000_0264. The bench SHALL check:
- tx stream is 24 4D 3E 02 64 01 02 65
- frame_done pulses once
- fifo_level ends at 0
REQ-032 Write CTRL 0x8001_00F5 with the FIFO empty. The bench SHALL check:
- tx stream is 24 4D 21 00 F5 F5
- busy falls in the same cycle frame_done pulses
REQ-033 During the payload phase, hold tx_ready=0 for 3 cycles. The bench SHALL check:
- tx_valid stays 1 with tx_data constant
- the stream is unchanged
REQ-034 Perform 17 DATA writes. The bench SHALL check:
- fifo_level = 16 and STATUS[8] = 1
- writing STATUS 0x100 clears [8]
REQ-035 With fifo_level=1, write CTRL with size=3 and start=1. The bench SHALL check:
- no tx_valid
- STATUS[9] = 1 and fifo_level = 1
- a start issued while busy also sets [9]
REQ-036 Assert wb_rst_i for 1 cycle after the 4th byte of a frame. The bench SHALL check:
- tx_valid = 0
- STATUS reads 0
- no frame_done
